// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Build macro RX_FIFO_EOP_EN: RX FIFO entries carry a last-of-packet flag above the byte.
package uart_pkg;

    localparam int unsigned UART_BYTE_W                = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH_DEFAULT = 16;

`ifdef RX_FIFO_EOP_EN
    localparam int unsigned UART_RX_FIFO_ENTRY_W = UART_BYTE_W + 1;
`else
    localparam int unsigned UART_RX_FIFO_ENTRY_W = UART_BYTE_W;
`endif

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Store one entry per write strobe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO downstream of the UART receiver.
// Build macro RX_FIFO_EOP_EN: enables the m_last port and end-of-packet tagging.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_BYTE_W-1:0] rx_data,
    input  logic                   rx_data_ready,
    input  logic                   rx_endofpacket,
    output logic [UART_BYTE_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
`ifdef RX_FIFO_EOP_EN
    output logic                   m_last,
`endif
    output logic [AW:0]            level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        overflow_q, overflow_d;
    logic        push, pop, drop;

    logic                            mem_we;
    logic [AW-1:0]                   mem_waddr;
    logic [UART_RX_FIFO_ENTRY_W-1:0] mem_wdata;
    logic [UART_RX_FIFO_ENTRY_W-1:0] mem_rdata;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign m_valid  = !empty;
    assign pop      = m_valid && m_ready;
    assign push     = rx_data_ready && (!full || pop);
    assign drop     = rx_data_ready && full && !pop;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign m_data   = mem_rdata[UART_BYTE_W-1:0];

    // Next pointers, occupancy and sticky overflow (a new drop beats a clear).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Pointer, level and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RX_FIFO_EOP_EN
    logic [UART_BYTE_W-1:0] newest_q, newest_d;
    logic [AW:0]            wr_prev;
    logic                   eop_tag;

    assign wr_prev = wr_ptr_q - PTR_ONE;
    assign m_last  = m_valid && mem_rdata[UART_BYTE_W];

    // Tagging an already stored entry rewrites it whole, using a shadow copy
    // of the newest byte so the single write port suffices.
    always_comb begin
        eop_tag   = rx_endofpacket && (level_d != '0);
        newest_d  = push ? rx_data : newest_q;
        mem_we    = push || eop_tag;
        mem_waddr = push ? wr_ptr_q[AW-1:0] : wr_prev[AW-1:0];
        mem_wdata = {eop_tag, newest_d};
    end

    // Shadow of the most recently pushed byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            newest_q <= '0;
        end else begin
            newest_q <= newest_d;
        end
    end
`else
    logic unused_eop;
    assign unused_eop = rx_endofpacket;

    // Plain byte write on every accepted push.
    always_comb begin
        mem_we    = push;
        mem_waddr = wr_ptr_q[AW-1:0];
        mem_wdata = rx_data;
    end
`endif

    uart_fifo_mem #(
        .W     (UART_RX_FIFO_ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed tests on a DEPTH=16 instance,
// randomized wrap test on a DEPTH=4 instance against a queue model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int unsigned DA = 16;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0] a_data, a_mdata;
    logic       a_rdy, a_eop, a_mready, a_clr;
    logic       a_mvalid, a_full, a_empty, a_ovf;
    logic [4:0] a_level;

    logic [7:0] b_data, b_mdata;
    logic       b_rdy, b_eop, b_mready, b_clr;
    logic       b_mvalid, b_full, b_empty, b_ovf;
    logic [2:0] b_level;

`ifdef RX_FIFO_EOP_EN
    logic a_last, b_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model of instance B: queue of {last, byte} plus sticky overflow.
    logic [8:0] qb[$];
    logic       ovfb;

    uart_rx_fifo #(.DEPTH(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(a_data), .rx_data_ready(a_rdy),
        .rx_endofpacket(a_eop), .m_data(a_mdata), .m_valid(a_mvalid), .m_ready(a_mready),
`ifdef RX_FIFO_EOP_EN
        .m_last(a_last),
`endif
        .level(a_level), .full(a_full), .empty(a_empty), .overflow(a_ovf),
        .clr_overflow(a_clr)
    );

    uart_rx_fifo #(.DEPTH(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(b_data), .rx_data_ready(b_rdy),
        .rx_endofpacket(b_eop), .m_data(b_mdata), .m_valid(b_mvalid), .m_ready(b_mready),
`ifdef RX_FIFO_EOP_EN
        .m_last(b_last),
`endif
        .level(b_level), .full(b_full), .empty(b_empty), .overflow(b_ovf),
        .clr_overflow(b_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance the model of B by one edge using the inputs currently driven.
    task automatic model_b_edge();
        int         sz;
        bit         is_full, pop, push, drop;
        logic [8:0] tmp;
        sz      = qb.size();
        is_full = (sz == int'(DB));
        pop     = (sz > 0) && b_mready;
        push    = b_rdy && (!is_full || pop);
        drop    = b_rdy && is_full && !pop;
        if (pop) void'(qb.pop_front());
        if (push) qb.push_back({1'b0, b_data});
`ifdef RX_FIFO_EOP_EN
        if (b_eop && qb.size() > 0) begin
            tmp = qb[qb.size() - 1];
            tmp[8] = 1'b1;
            qb[qb.size() - 1] = tmp;
        end
`else
        tmp = '0;
`endif
        if (drop) ovfb = 1'b1;
        else if (b_clr) ovfb = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        {a_data, a_rdy, a_eop, a_mready, a_clr} = '0;
        {b_data, b_rdy, b_eop, b_mready, b_clr} = '0;
        qb.delete();
        ovfb = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (a_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", a_level); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", a_empty); end
        n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", a_full); end
        n_checks++; if (a_mvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b expected 0", a_mvalid); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", a_ovf); end
        n_checks++; if (b_empty !== 1'b1 || b_level !== 3'd0) begin n_fail++; $display("FAIL reset_b: got empty=%b level=%0d expected 1/0", b_empty, b_level); end
`ifdef RX_FIFO_EOP_EN
        n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL reset_mlast: got %b expected 0", a_last); end
`endif
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_q [3] = '{8'h55, 8'hA3, 8'h0F};
        a_mready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_rdy = 1'b1; a_data = exp_q[i]; tick();
        end
        a_rdy = 1'b0;
        n_checks++; if (a_level !== 5'd3) begin n_fail++; $display("FAIL basic_level: got %0d expected 3", a_level); end
        n_checks++; if (a_mdata !== 8'h55) begin n_fail++; $display("FAIL basic_head: got %0h expected 55", a_mdata); end
        n_checks++; if (a_empty !== 1'b0 || a_mvalid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got empty=%b valid=%b expected 0/1", a_empty, a_mvalid); end
        a_mready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (a_mdata !== exp_q[i]) begin n_fail++; $display("FAIL basic_order%0d: got %0h expected %0h", i, a_mdata, exp_q[i]); end
            tick();
        end
        a_mready = 1'b0;
        n_checks++; if (a_empty !== 1'b1 || a_level !== 5'd0 || a_mvalid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got empty=%b level=%0d valid=%b expected 1/0/0", a_empty, a_level, a_mvalid); end
    endtask

    task automatic test_overflow();
        a_mready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a_rdy = 1'b1; a_data = 8'(i); tick();
            if (i == 14) begin
                n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full15: got %b expected 0", a_full); end
            end
            if (i == 15) begin
                n_checks++; if (a_full !== 1'b1 || a_level !== 5'd16 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_full16: got full=%b level=%0d ovf=%b expected 1/16/0", a_full, a_level, a_ovf); end
            end
        end
        a_rdy = 1'b0;
        n_checks++; if (a_ovf !== 1'b1 || a_level !== 5'd16) begin n_fail++; $display("FAIL ovf_drop: got ovf=%b level=%0d expected 1/16", a_ovf, a_level); end
        a_mready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (a_mdata !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain%0d: got %0h expected %0h", i, a_mdata, i); end
            tick();
        end
        a_mready = 1'b0;
        n_checks++; if (a_empty !== 1'b1 || a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got empty=%b ovf=%b expected 1/1", a_empty, a_ovf); end
    endtask

    task automatic test_clr_overflow();
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b expected 0", a_ovf); end
        for (int i = 0; i < 16; i++) begin
            a_rdy = 1'b1; a_data = 8'(8'h20 + i); tick();
        end
        a_rdy = 1'b0;
        n_checks++; if (a_full !== 1'b1 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_fill: got full=%b ovf=%b expected 1/0", a_full, a_ovf); end
        a_rdy = 1'b1; a_data = 8'hEE; a_clr = 1'b1; tick();
        a_rdy = 1'b0; a_clr = 1'b0;
        n_checks++; if (a_ovf !== 1'b1 || a_level !== 5'd16) begin n_fail++; $display("FAIL clr_vs_drop: got ovf=%b level=%0d expected 1/16", a_ovf, a_level); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d;
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        a_rdy = 1'b1; a_data = 8'h99; a_mready = 1'b1; tick();
        a_rdy = 1'b0; a_mready = 1'b0;
        n_checks++; if (a_level !== 5'd16 || a_full !== 1'b1 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_state: got level=%0d full=%b ovf=%b expected 16/1/0", a_level, a_full, a_ovf); end
        n_checks++; if (a_mdata !== 8'h21) begin n_fail++; $display("FAIL fpp_head: got %0h expected 21", a_mdata); end
        a_mready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 8'(8'h21 + i) : 8'h99;
            n_checks++; if (a_mdata !== exp_d) begin n_fail++; $display("FAIL fpp_drain%0d: got %0h expected %0h", i, a_mdata, exp_d); end
            tick();
        end
        a_mready = 1'b0;
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: got %b expected 1", a_empty); end
    endtask

    task automatic test_wrap_random();
        int unsigned push_pct, pop_pct;
        logic [8:0]  head;
        for (int i = 0; i < 300; i++) begin
            push_pct = (i < 100) ? 75 : (i < 200) ? 50 : 25;
            pop_pct  = (i < 100) ? 30 : (i < 200) ? 50 : 80;
            b_rdy    = ($urandom_range(0, 99) < push_pct);
            b_data   = 8'($urandom);
            b_mready = ($urandom_range(0, 99) < pop_pct);
            b_eop    = ($urandom_range(0, 5) == 0);
            b_clr    = ($urandom_range(0, 15) == 0);
            model_b_edge();
            tick();
            n_checks++; if (b_level !== 3'(qb.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", i, b_level, qb.size()); end
            n_checks++; if (b_full !== (qb.size() == int'(DB))) begin n_fail++; $display("FAIL rnd_full@%0d: got %b expected %b", i, b_full, qb.size() == int'(DB)); end
            n_checks++; if (b_empty !== (qb.size() == 0) || b_mvalid !== (qb.size() != 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got empty=%b valid=%b size=%0d", i, b_empty, b_mvalid, qb.size()); end
            n_checks++; if (b_ovf !== ovfb) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b expected %b", i, b_ovf, ovfb); end
            if (qb.size() > 0) begin
                head = qb[0];
                n_checks++; if (b_mdata !== head[7:0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %0h expected %0h", i, b_mdata, head[7:0]); end
`ifdef RX_FIFO_EOP_EN
                n_checks++; if (b_last !== head[8]) begin n_fail++; $display("FAIL rnd_last@%0d: got %b expected %b", i, b_last, head[8]); end
`endif
            end
        end
        {b_rdy, b_mready, b_eop, b_clr} = '0;
    endtask

`ifdef RX_FIFO_EOP_EN
    task automatic test_eop();
        a_mready = 1'b0;
        a_rdy = 1'b1; a_data = 8'h01; tick();
        a_data = 8'h02; tick();
        a_rdy = 1'b0; a_eop = 1'b1; tick(); a_eop = 1'b0;
        n_checks++; if (a_mdata !== 8'h01 || a_last !== 1'b0) begin n_fail++; $display("FAIL eop_first: got data=%0h last=%b expected 01/0", a_mdata, a_last); end
        a_mready = 1'b1; tick();
        n_checks++; if (a_mdata !== 8'h02 || a_last !== 1'b1) begin n_fail++; $display("FAIL eop_second: got data=%0h last=%b expected 02/1", a_mdata, a_last); end
        tick(); a_mready = 1'b0;
        a_rdy = 1'b1; a_data = 8'h03; a_eop = 1'b1; tick();
        a_rdy = 1'b0; a_eop = 1'b0;
        n_checks++; if (a_mdata !== 8'h03 || a_last !== 1'b1) begin n_fail++; $display("FAIL eop_with_push: got data=%0h last=%b expected 03/1", a_mdata, a_last); end
        a_mready = 1'b1; a_eop = 1'b1; tick();
        a_mready = 1'b0; a_eop = 1'b0;
        a_rdy = 1'b1; a_data = 8'h04; tick(); a_rdy = 1'b0;
        n_checks++; if (a_mdata !== 8'h04 || a_last !== 1'b0) begin n_fail++; $display("FAIL eop_discard: got data=%0h last=%b expected 04/0", a_mdata, a_last); end
        a_mready = 1'b1; tick(); a_mready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            a_rdy = (i < 3); a_data = 8'(8'h11 + i);
            b_rdy = 1'b1; b_data = 8'(8'hB0 + i);
            tick();
        end
        a_rdy = 1'b0; b_rdy = 1'b0;
        n_checks++; if (a_level !== 5'd3 || b_ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got a_level=%0d b_ovf=%b expected 3/1", a_level, b_ovf); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (a_empty !== 1'b1 || a_mvalid !== 1'b0 || a_level !== 5'd0) begin n_fail++; $display("FAIL mid_a: got empty=%b valid=%b level=%0d expected 1/0/0", a_empty, a_mvalid, a_level); end
        n_checks++; if (b_ovf !== 1'b0 || b_empty !== 1'b1 || b_full !== 1'b0) begin n_fail++; $display("FAIL mid_b: got ovf=%b empty=%b full=%b expected 0/1/0", b_ovf, b_empty, b_full); end
        #4 rst_n = 1'b1;
        qb.delete(); ovfb = 1'b0;
        tick();
        a_rdy = 1'b1; a_data = 8'h5A; tick(); a_rdy = 1'b0;
        n_checks++; if (a_level !== 5'd1 || a_mdata !== 8'h5A) begin n_fail++; $display("FAIL mid_after: got level=%0d data=%0h expected 1/5a", a_level, a_mdata); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_clr_overflow();
        test_full_push_pop();
        test_wrap_random();
`ifdef RX_FIFO_EOP_EN
        test_eop();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
